// File: rtl/stopwatch_core_if.sv
// Control and display bundle for stopwatch_core.
//   master : drives the debounced command levels, tick source select and speed
//            (board logic or a testbench).
//   slave  : the stopwatch engine; returns the live count, the displayed value,
//            the seven-segment pattern and the status indicators.
// Every command input is a level that is already synchronous to the core clock.
interface stopwatch_core_if #(
  parameter int DIGITS  = 4,
  parameter int SPEED_W = 5
);
  // Commands and tick configuration
  logic                 Clk2;
  logic                 ClkSel;
  logic                 Clear;
  logic                 Stop;
  logic                 Up;
  logic                 Down;
  logic                 Lap;
  logic [SPEED_W-1:0]   Speed;

  // Count, display and status
  logic [4*DIGITS-1:0]  Count;
  logic [4*DIGITS-1:0]  Display;
  logic [7*DIGITS-1:0]  Seg;
  logic                 ModeUp;
  logic                 ModeDown;
  logic                 ModeStop;
  logic                 LapActive;
  logic                 Limit;
  logic                 TickLed;

  modport master (
    output Clk2, ClkSel, Clear, Stop, Up, Down, Lap, Speed,
    input  Count, Display, Seg, ModeUp, ModeDown, ModeStop, LapActive, Limit, TickLed
  );

  modport slave (
    input  Clk2, ClkSel, Clear, Stop, Up, Down, Lap, Speed,
    output Count, Display, Seg, ModeUp, ModeDown, ModeStop, LapActive, Limit, TickLed
  );
endinterface

// File: rtl/stopwatch_core.sv
// stopwatch_core: N-digit BCD up/down stopwatch engine.
//
// Ports
//   Clk    : sole clock, all state changes on its rising edge.
//   Reset  : synchronous, active-high full initialisation.
//   sw     : stopwatch_core_if.slave
//              Clk2/ClkSel  external tick level / tick source select
//              Clear, Stop, Up, Down, Lap  command levels (rising edge = command)
//              Speed        prescaler speed select
//              Count        live BCD count, digit 0 least significant
//              Display      Count, or the value frozen by a lap hold
//              Seg          per-digit seven-segment pattern (bit 0 = a)
//              ModeUp/ModeDown/ModeStop, LapActive, Limit (1-cycle), TickLed
//
// Ticks come from a free-running prescaler ((Speed+1)<<PRESC_SHIFT cycles) or
// from rising edges of Clk2. A tick moves the count only in UP or DOWN, and it
// always acts on the state held before the edge, so a command arriving in the
// same cycle changes the mode but not how that tick is applied.
module stopwatch_core #(
  parameter int DIGITS         = 4,
  parameter int SPEED_W        = 5,
  parameter int PRESC_SHIFT    = 20,
  parameter bit WRAP           = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  stopwatch_core_if.slave  sw
);

  localparam int CW = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;
  // Wide enough for the largest terminal value ((2^SPEED_W) << PRESC_SHIFT) - 1
  // plus one spare bit so the +1 before the shift cannot overflow.
  localparam int PW = SPEED_W + PRESC_SHIFT + 1;

  localparam logic [CW-1:0] CNT_MAX  = {DIGITS{4'h9}};
  localparam logic [CW-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_e          state_q,      state_d;
  logic [CW-1:0]   count_q,      count_d;
  logic [CW-1:0]   lap_value_q,  lap_value_d;
  logic            lap_active_q, lap_active_d;
  logic            limit_q,      limit_d;
  logic            tick_led_q,   tick_led_d;
  logic [PW-1:0]   presc_q,      presc_d;

  // One-deep history of each command level for rising-edge detection
  logic            clear_q, stop_q, up_q, down_q, lap_q, clk2_q;

  // -------------------------------------------------------------------------
  // Command edges
  // -------------------------------------------------------------------------
  logic clear_cmd, stop_cmd, up_cmd, down_cmd, lap_cmd, clk2_rise;

  assign clear_cmd = sw.Clear & ~clear_q;
  assign stop_cmd  = sw.Stop  & ~stop_q;
  assign up_cmd    = sw.Up    & ~up_q;
  assign down_cmd  = sw.Down  & ~down_q;
  assign lap_cmd   = sw.Lap   & ~lap_q;
  assign clk2_rise = sw.Clk2  & ~clk2_q;

  // -------------------------------------------------------------------------
  // Tick source
  // -------------------------------------------------------------------------
  logic [PW-1:0] presc_term;
  logic          tick;

  assign presc_term = ((PW'(sw.Speed) + PW'(1)) << PRESC_SHIFT) - PW'(1);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    presc_d = '0;
    tick    = 1'b0;
    if (sw.ClkSel) begin
      tick = clk2_rise;
    end else if (presc_q >= presc_term) begin
      // >= rather than == so lowering Speed mid-period still terminates
      tick = 1'b1;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // BCD neighbours of the current count (ripple carry / borrow per digit)
  // -------------------------------------------------------------------------
  logic [CW-1:0] count_inc, count_dec;

  always_comb begin
    logic carry;
    logic borrow;
    count_inc = count_q;
    count_dec = count_q;
    carry     = 1'b1;
    borrow    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i+:4] == 4'd9) begin
          count_inc[4*i+:4] = 4'd0;
        end else begin
          count_inc[4*i+:4] = count_q[4*i+:4] + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i+:4] == 4'd0) begin
          count_dec[4*i+:4] = 4'd9;
        end else begin
          count_dec[4*i+:4] = count_q[4*i+:4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic: tick first (on the old state), then lap, then the
  // state commands, whose priority overrides any state change from the tick.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    lap_value_d  = lap_value_q;
    lap_active_d = lap_active_q;
    limit_d      = 1'b0;
    tick_led_d   = tick_led_q;

    if (tick && (state_q == ST_UP || state_q == ST_DOWN)) begin
      tick_led_d = ~tick_led_q;
      if (state_q == ST_UP) begin
        if (count_q == CNT_MAX) begin
          limit_d = 1'b1;
          if (WRAP) count_d = CNT_ZERO;
          else      state_d = ST_STOP;
        end else begin
          count_d = count_inc;
        end
      end else begin
        if (count_q == CNT_ZERO) begin
          limit_d = 1'b1;
          if (WRAP) count_d = CNT_MAX;
          else      state_d = ST_STOP;
        end else begin
          count_d = count_dec;
        end
      end
    end

    // Lap latches the pre-tick count, even when a tick lands on the same edge
    if (lap_cmd) begin
      if (!lap_active_q) begin
        lap_active_d = 1'b1;
        lap_value_d  = count_q;
      end else begin
        lap_active_d = 1'b0;
      end
    end

    // A Stop edge wins arbitration even in IDLE/STOP, where it changes nothing
    if (clear_cmd) begin
      state_d      = ST_IDLE;
      count_d      = CNT_ZERO;
      lap_active_d = 1'b0;
    end else if (stop_cmd) begin
      if (state_q == ST_UP || state_q == ST_DOWN) state_d = ST_STOP;
    end else if (up_cmd) begin
      state_d = ST_UP;
    end else if (down_cmd) begin
      state_d = ST_DOWN;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before this edge, independent of block order.
    if (Reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      lap_value_q  <= '0;
      lap_active_q <= 1'b0;
      limit_q      <= 1'b0;
      tick_led_q   <= 1'b0;
      presc_q      <= '0;
      clear_q      <= 1'b0;
      stop_q       <= 1'b0;
      up_q         <= 1'b0;
      down_q       <= 1'b0;
      lap_q        <= 1'b0;
      clk2_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      lap_value_q  <= lap_value_d;
      lap_active_q <= lap_active_d;
      limit_q      <= limit_d;
      tick_led_q   <= tick_led_d;
      presc_q      <= presc_d;
      clear_q      <= sw.Clear;
      stop_q       <= sw.Stop;
      up_q         <= sw.Up;
      down_q       <= sw.Down;
      lap_q        <= sw.Lap;
      clk2_q       <= sw.Clk2;
    end
  end

  // -------------------------------------------------------------------------
  // Display and segment decode
  // -------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)        //  gfedcba
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  logic [CW-1:0] display;
  logic [SW-1:0] seg;

  assign display = lap_active_q ? lap_value_q : count_q;

  always_comb begin
    seg = '0;
    for (int i = 0; i < DIGITS; i++) begin
      seg[7*i+:7] = seg_decode(display[4*i+:4]) ^ {7{SEG_ACTIVE_LOW}};
    end
  end

  assign sw.Count     = count_q;
  assign sw.Display   = display;
  assign sw.Seg       = seg;
  assign sw.ModeUp    = (state_q == ST_UP);
  assign sw.ModeDown  = (state_q == ST_DOWN);
  assign sw.ModeStop  = (state_q == ST_STOP);
  assign sw.LapActive = lap_active_q;
  assign sw.Limit     = limit_q;
  assign sw.TickLed   = tick_led_q;

endmodule
